cv32e40p_obi_tb_periph: RTL
===========================

// Module: cv32e40p_obi_tb_periph
// PURPOSE
//  OBI data-bus responder for the core testbench. Serves a small memory-mapped register window: stdout char FIFO,
//  exit/test-status registers, scratch and cycle counter. Sits beside the RAM on the core's data port, behind the
//  testbench address decode. Has programmable grant stall and response latency to stress the core's LSU handshake.
// PARAMETERS
//  BASE_ADDR        32'h2000_0000  base of 64-byte window; addr_i[31:6] must match, else no grant
//  GNT_STALL        0              cycles gnt_o is withheld after req_i is seen (0 = same-cycle grant)
//  RSP_LATENCY      1              cycles from grant to rvalid_o (>=1)
//  MAX_OUTSTANDING  2              max granted-but-unanswered transactions (>=1)
//  CHAR_FIFO_DEPTH  8              stdout FIFO entries, power of 2, >=2
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   synchronous active-low reset
//  req_i           in   1   OBI address-phase request
//  gnt_o           out  1   OBI grant
//  addr_i          in   32  byte address
//  we_i            in   1   1 = write
//  be_i            in   4   byte enables
//  wdata_i         in   32  write data
//  rvalid_o        out  1   OBI response valid (reads and writes)
//  rdata_o         out  32  read data, valid with rvalid_o
//  char_valid_o    out  1   stdout FIFO non-empty
//  char_o          out  8   FIFO head character
//  char_ready_i    in   1   consumer pops head when char_valid_o && char_ready_i
//  tests_passed_o  out  1   sticky
//  tests_failed_o  out  1   sticky
//  exit_valid_o    out  1   sticky
//  exit_value_o    out  32  value of first EXIT write
// BEHAVIOUR
//  Reset: synchronous on rst_ni=0. All outputs 0. FIFO empty. Stall counter, response pipe, cycle counter and
//   SCRATCH cleared. Reset mid-transaction discards in-flight responses; no rvalid_o is issued for them.
//  Register map (offset = addr_i[5:2]):
//   0x00 STDOUT  W: push wdata_i[7:0] if be_i[0]. R: 0.
//   0x04 EXIT    W: first write sets exit_valid_o, captures wdata_i. Later writes ignored. R: exit_value_o.
//   0x08 STATUS  W: 32'd123456789 sets tests_passed_o, 32'd1 sets tests_failed_o, other values ignored.
//                R: {30'b0, tests_failed_o, tests_passed_o}.
//   0x0C SCRATCH R/W, byte-enable masked.
//   0x10 FIFOCNT R: number of FIFO entries, zero-extended. W ignored.
//   0x14 CYCLES  R: free-running 32-bit counter, +1 every cycle out of reset, wraps 0xFFFF_FFFF->0. W ignored.
//   other offsets: read returns 0, write ignored, normal response.
//  Grant: gnt_o is combinational and is 1 only when all of the following hold:
//   - req_i=1 and the address is in the window;
//   - stall count == GNT_STALL;
//   - outstanding < MAX_OUTSTANDING, or outstanding == MAX_OUTSTANDING with a response retiring this cycle;
//   - the access is not a STDOUT write with be_i[0]=1 while the FIFO is full. A full FIFO is a full block, even
//     with a simultaneous pop.
//  Stall counter: increments while req_i=1 and the count is < GNT_STALL. Clears on grant and when req_i=0.
//  Response: granted transaction gets rvalid_o exactly RSP_LATENCY cycles after the grant edge. Responses are in
//   order. Implemented as a RSP_LATENCY-deep valid/data shift pipe.
//  Read data: sampled at the grant cycle, so CYCLES returns the count at grant. Register side effects (push,
//   sticky set, scratch write) commit at the grant edge.
//  Outstanding: number of valid pipe entries. Back-to-back grants every cycle need MAX_OUTSTANDING >= RSP_LATENCY.
//  FIFO: push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged. Pop on empty
//   is impossible (char_valid_o=0). Pointers wrap modulo CHAR_FIFO_DEPTH.
//  STATUS: a write of 123456789 and a write of 1 may both occur; both flags are then 1.
// TESTING
//  T1 reset, then write 0x41,0x42 to STDOUT, char_ready_i=1 -> char_o 0x41 then 0x42, each rvalid 1 cycle after gnt
//  T2 char_ready_i=0, 9 STDOUT writes, depth 8 -> first 8 granted, 9th gnt_o=0 until one pop; FIFOCNT reads 8
//  T3 GNT_STALL=3, RSP_LATENCY=2, read CYCLES -> gnt 3 cycles after req, rvalid 2 later, rdata = count at grant
//  T4 MAX_OUTSTANDING=1, RSP_LATENCY=3, req held -> grants spaced 3 cycles; retire+grant same cycle honoured
//  T5 write STATUS 123456789, then EXIT 0x5, then EXIT 0x7 -> tests_passed_o=1, exit_valid_o=1, exit_value_o=5
//  T6 SCRATCH write 0xAABBCCDD be=4'b0101, rst_ni=0 during in-flight read -> no rvalid; SCRATCH 0 after reset

Source files
------------

// File: rtl/cv32e40p_obi_tb_periph.sv
// OBI data-bus responder for the core testbench: stdout char FIFO, exit/status flags,
// scratch and cycle counter in a 64-byte window, with programmable grant stall and response latency.
module cv32e40p_obi_tb_periph #(
  parameter logic [31:0] BASE_ADDR       = 32'h2000_0000,
  parameter int          GNT_STALL       = 0,
  parameter int          RSP_LATENCY     = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          CHAR_FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int SW = $clog2(GNT_STALL + 2);
  localparam int PW = $clog2(CHAR_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SW-1:0] STALL_MAX   = SW'(GNT_STALL);
  localparam logic [31:0]   STATUS_PASS = 32'd123456789;
  localparam logic [31:0]   STATUS_FAIL = 32'd1;

  localparam logic [3:0] OFF_STDOUT  = 4'h0;
  localparam logic [3:0] OFF_EXIT    = 4'h1;
  localparam logic [3:0] OFF_STATUS  = 4'h2;
  localparam logic [3:0] OFF_SCRATCH = 4'h3;
  localparam logic [3:0] OFF_FIFOCNT = 4'h4;
  localparam logic [3:0] OFF_CYCLES  = 4'h5;

  logic                   in_window;
  logic [3:0]             offset;
  logic                   stdout_push_req;
  logic                   slot_free;
  logic                   gnt;
  logic [SW-1:0]          stall_cnt;
  logic [RSP_LATENCY-1:0] vld_pipe;
  logic [31:0]            data_pipe [RSP_LATENCY];
  logic [31:0]            outstanding;
  logic [7:0]             fifo_mem [CHAR_FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_cnt;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  logic [31:0]            scratch;
  logic [31:0]            cycles;
  logic [31:0]            read_data;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];

  assign in_window       = (addr_i[31:6] == BASE_ADDR[31:6]);
  assign offset          = addr_i[5:2];
  assign stdout_push_req = we_i && (offset == OFF_STDOUT) && be_i[0];

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RSP_LATENCY; i++) begin
      outstanding = outstanding + 32'(vld_pipe[i]);
    end
  end

  // A slot frees up in the same cycle the oldest response retires.
  assign slot_free = (outstanding < 32'(MAX_OUTSTANDING)) ||
                     ((outstanding == 32'(MAX_OUTSTANDING)) && vld_pipe[RSP_LATENCY-1]);

  assign gnt   = rst_ni && req_i && in_window && (stall_cnt == STALL_MAX) && slot_free &&
                 !(stdout_push_req && fifo_full);
  assign gnt_o = gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (!req_i || gnt) begin
      stall_cnt <= '0;
    end else if (stall_cnt < STALL_MAX) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  always_comb begin
    read_data = '0;
    case (offset)
      OFF_EXIT:    read_data = exit_value_o;
      OFF_STATUS:  read_data = {30'b0, tests_failed_o, tests_passed_o};
      OFF_SCRATCH: read_data = scratch;
      OFF_FIFOCNT: read_data = 32'(fifo_cnt);
      OFF_CYCLES:  read_data = cycles;
      default:     read_data = '0;
    endcase
  end

  // Read data is captured at grant time and travels with its valid bit down the pipe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) begin
        data_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= gnt;
      data_pipe[0] <= (gnt && !we_i) ? read_data : '0;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign rvalid_o = vld_pipe[RSP_LATENCY-1];
  assign rdata_o  = data_pipe[RSP_LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      scratch        <= '0;
      cycles         <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (gnt && we_i) begin
        case (offset)
          OFF_EXIT: begin
            if (!exit_valid_o) begin
              exit_valid_o <= 1'b1;
              exit_value_o <= wdata_i;
            end
          end
          OFF_STATUS: begin
            if (wdata_i == STATUS_PASS) tests_passed_o <= 1'b1;
            if (wdata_i == STATUS_FAIL) tests_failed_o <= 1'b1;
          end
          OFF_SCRATCH: begin
            for (int b = 0; b < 4; b++) begin
              if (be_i[b]) scratch[8*b +: 8] <= wdata_i[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign push      = gnt && stdout_push_req;
  assign pop       = char_valid_o && char_ready_i;
  assign fifo_full = (fifo_cnt == CW'(CHAR_FIFO_DEPTH));

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  assign char_valid_o = (fifo_cnt != '0);
  assign char_o       = char_valid_o ? fifo_mem[rd_ptr] : 8'h00;

endmodule
